// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher and related event/indicator blocks:
// FSM state encoding and the ms-to-clock-cycles conversion.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // 64-bit intermediate so large clock rates times long intervals cannot wrap.
  function automatic logic [31:0] ms_to_cycles(input longint unsigned freq_hz,
                                               input longint unsigned ms);
    longint unsigned cycles_v;
    cycles_v = (freq_hz * ms) / 64'd1000;
    return cycles_v[31:0];
  endfunction

endpackage

// File: rtl/edge_rise_detect.sv
// Rising-edge detector: registered previous level, combinational rise strobe.
// A level already high when reset releases reports a rise on the first cycle.
module edge_rise_detect (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Sig,
  output logic o_Rise
);

  logic sig_prev_r;

  // Previous-level register, cleared by reset.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sig_prev_r <= 1'b0;
    end else begin
      sig_prev_r <= i_Sig;
    end
  end

  assign o_Rise = i_Sig & ~sig_prev_r;

endmodule

// File: rtl/pulse_stretcher.sv
// Turns each rising edge of i_Event into one visible blink of o_LED with a fixed
// on-time and a minimum off-gap; edges arriving mid-blink are queued up to MAX_PENDING.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ = 25_000_000,
  parameter int unsigned ON_MS         = 50,
  parameter int unsigned OFF_MS        = 50,
  parameter int unsigned MAX_PENDING   = 7
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Event,
  output logic o_LED,
  output logic o_Busy,
  output logic o_Overflow
);

  localparam logic [31:0] c_ON_LIMIT  = ms_to_cycles(64'(CLOCK_FREQ_HZ), 64'(ON_MS));
  localparam logic [31:0] c_OFF_LIMIT = ms_to_cycles(64'(CLOCK_FREQ_HZ), 64'(OFF_MS));
  localparam int unsigned PW          = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] c_PEND_MAX  = PW'(MAX_PENDING);
  localparam logic [PW-1:0] c_PEND_ONE  = PW'(1);
  localparam logic [PW-1:0] c_PEND_ZERO = PW'(0);

  if (c_ON_LIMIT == 32'd0) begin : g_on_limit_zero
    $error("pulse_stretcher: ON_MS at CLOCK_FREQ_HZ gives a zero-cycle on-time");
  end
  if (c_OFF_LIMIT == 32'd0) begin : g_off_limit_zero
    $error("pulse_stretcher: OFF_MS at CLOCK_FREQ_HZ gives a zero-cycle off-gap");
  end

  state_t        state_r, state_nxt_s;
  logic [31:0]   timer_r, timer_nxt_s;
  logic [PW-1:0] pending_r, pend_nxt_s;
  logic          led_r, led_nxt_s;
  logic          ovf_r, ovf_set_s;
  logic          deq_s;
  logic          rise_s;

  edge_rise_detect u_edge_rise_detect (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sig   (i_Event),
    .o_Rise  (rise_s)
  );

  // Blink sequencing: IDLE waits for work, ON holds the LED, GAP enforces the off-time.
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r + 32'd1;
    led_nxt_s   = led_r;
    deq_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        timer_nxt_s = 32'd0;
        if (pending_r != c_PEND_ZERO) begin
          state_nxt_s = ST_ON;
          deq_s       = 1'b1;
          led_nxt_s   = 1'b1;
        end else begin
          led_nxt_s   = 1'b0;
        end
      end
      ST_ON: begin
        if (timer_r == c_ON_LIMIT - 32'd1) begin
          state_nxt_s = ST_GAP;
          timer_nxt_s = 32'd0;
          led_nxt_s   = 1'b0;
        end else begin
          led_nxt_s   = 1'b1;
        end
      end
      ST_GAP: begin
        led_nxt_s = 1'b0;
        if (timer_r == c_OFF_LIMIT - 32'd1) begin
          timer_nxt_s = 32'd0;
          // Queued work skips IDLE so back-to-back gaps are exactly the off-time.
          if (pending_r != c_PEND_ZERO) begin
            state_nxt_s = ST_ON;
            deq_s       = 1'b1;
            led_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        timer_nxt_s = 32'd0;
        led_nxt_s   = 1'b0;
      end
    endcase
  end

  // Pending-event counter; a rise coinciding with a dequeue is never dropped.
  always_comb begin
    pend_nxt_s = pending_r;
    ovf_set_s  = 1'b0;
    case ({rise_s, deq_s})
      2'b10: begin
        if (pending_r == c_PEND_MAX) begin
          ovf_set_s  = 1'b1;
        end else begin
          pend_nxt_s = pending_r + c_PEND_ONE;
        end
      end
      2'b01:   pend_nxt_s = pending_r - c_PEND_ONE;
      default: pend_nxt_s = pending_r;
    endcase
  end

  // State, timer, counter and output registers.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_r   <= ST_IDLE;
      timer_r   <= 32'd0;
      pending_r <= c_PEND_ZERO;
      led_r     <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      pending_r <= pend_nxt_s;
      led_r     <= led_nxt_s;
      ovf_r     <= ovf_r | ovf_set_s;
    end
  end

  assign o_LED      = led_r;
  assign o_Overflow = ovf_r;
  assign o_Busy     = (state_r != ST_IDLE) | (pending_r != c_PEND_ZERO);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Self-checking bench for pulse_stretcher: a blink-schedule model predicts o_LED,
// o_Busy and o_Overflow every cycle; directed scenarios add literal expectations.
module tb_pulse_stretcher;

  localparam int ON   = 4;
  localparam int OFF  = 3;
  localparam int MAXP = 3;
  localparam int SLEN = 200;

  logic clk = 1'b0;
  logic rst_n, ev;
  logic led, busy, ovf;

  always #5 clk = ~clk;

  pulse_stretcher #(
    .CLOCK_FREQ_HZ (1000),
    .ON_MS         (4),
    .OFF_MS        (3),
    .MAX_PENDING   (3)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Event    (ev),
    .o_LED      (led),
    .o_Busy     (busy),
    .o_Overflow (ovf)
  );

  int n_checks = 0;
  int n_fails  = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted event is assigned a blink start edge
  // s = max(rise_edge + 1, previous_start + ON + OFF).
  int q[$];
  int m_e, last_s, cur_s, m_blinks, pend_before, s_v;
  bit last_valid, cur_valid, m_prev, m_ovf, m_led, m_busy, rise_v, deq_v;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_e = 0; q.delete(); last_valid = 0; cur_valid = 0;
      m_prev = 0; m_ovf = 0; m_blinks = 0;
    end else begin
      m_e++;
      rise_v = ev && !m_prev;
      m_prev = ev;
      pend_before = q.size();
      deq_v = (q.size() > 0) && (q[0] == m_e);
      if (deq_v) begin
        cur_s = q.pop_front();
        cur_valid = 1;
        m_blinks++;
      end
      if (rise_v) begin
        if (pend_before < MAXP || deq_v) begin
          s_v = m_e + 1;
          if (last_valid && (last_s + ON + OFF > s_v)) s_v = last_s + ON + OFF;
          q.push_back(s_v);
          last_s = s_v;
          last_valid = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
    m_led  = cur_valid && (m_e < cur_s + ON);
    m_busy = (cur_valid && (m_e <= cur_s + ON + OFF - 1)) || (q.size() != 0);
  end

  // Observed statistics of the DUT output, for the literal scenario checks.
  int st_led_cycles, st_led_rises, st_first_rise_e, st_last_rise_e, st_last_busy_e;
  bit prev_led_obs;

  always @(negedge clk) begin
    if (chk_en) begin
      check("o_LED", 32'(led), 32'(m_led));
      check("o_Busy", 32'(busy), 32'(m_busy));
      check("o_Overflow", 32'(ovf), 32'(m_ovf));
      if (led === 1'b1) begin
        st_led_cycles++;
        if (!prev_led_obs) begin
          st_led_rises++;
          if (st_first_rise_e < 0) st_first_rise_e = m_e;
          st_last_rise_e = m_e;
        end
      end
      prev_led_obs = (led === 1'b1);
      if (busy === 1'b1) st_last_busy_e = m_e;
    end
  end

  bit ev_sched[SLEN];
  bit rst_sched[SLEN];

  task automatic clear_sched();
    for (int i = 0; i < SLEN; i++) begin
      ev_sched[i] = 1'b0;
      rst_sched[i] = 1'b0;
    end
  endtask

  // Reset at edge 0, then apply the schedule for edges 1..n-1.
  task automatic run_scen(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    ev = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    st_led_cycles = 0; st_led_rises = 0; st_first_rise_e = -1;
    st_last_rise_e = -1; st_last_busy_e = -1; prev_led_obs = 1'b0;
    for (int k = 1; k < n; k++) begin
      rst_n = !rst_sched[k];
      ev = ev_sched[k];
      @(negedge clk);
      #1;
      if (rst_sched[k]) begin
        check("rst_led", 32'(led), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
      end
    end
    rst_n = 1'b1;
    ev = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ev = 1'b0;

    // Single one-cycle pulse.
    clear_sched();
    ev_sched[10] = 1'b1;
    run_scen(40);
    check("s1_led_cycles", st_led_cycles, 4);
    check("s1_blinks", st_led_rises, 1);
    check("s1_first_led", st_first_rise_e, 11);
    check("s1_last_busy", st_last_busy_e, 17);
    check("s1_ovf", 32'(ovf), 32'd0);

    // Level held high for 20 cycles is a single event.
    clear_sched();
    for (int i = 10; i < 30; i++) ev_sched[i] = 1'b1;
    run_scen(50);
    check("s2_blinks", st_led_rises, 1);
    check("s2_led_cycles", st_led_cycles, 4);

    // Three close pulses give three separated blinks.
    clear_sched();
    ev_sched[10] = 1'b1; ev_sched[12] = 1'b1; ev_sched[14] = 1'b1;
    run_scen(50);
    check("s3_blinks", st_led_rises, 3);
    check("s3_led_cycles", st_led_cycles, 12);
    check("s3_busy_end", 32'(busy), 32'd0);

    // Six pulses saturate the queue and set the sticky overflow.
    clear_sched();
    for (int i = 0; i < 6; i++) ev_sched[10 + 2 * i] = 1'b1;
    run_scen(70);
    check("s4_ovf", 32'(ovf), 32'd1);
    check("s4_blinks", st_led_rises, m_blinks);
    check("s4_busy_end", 32'(busy), 32'd0);

    // Pulse on the exact edge a GAP dequeues the second blink.
    clear_sched();
    ev_sched[10] = 1'b1; ev_sched[12] = 1'b1; ev_sched[18] = 1'b1;
    run_scen(50);
    check("s5_blinks", st_led_rises, 3);
    check("s5_led_cycles", st_led_cycles, 12);
    check("s5_last_start", st_last_rise_e, 25);

    // Reset during the second ON cycle, then a fresh pulse.
    clear_sched();
    ev_sched[10] = 1'b1; rst_sched[13] = 1'b1; ev_sched[20] = 1'b1;
    run_scen(50);
    check("s6_blinks", st_led_rises, 2);
    check("s6_led_cycles", st_led_cycles, 6);
    check("s6_restart", st_last_rise_e, 8);

    // Random traffic with occasional resets.
    for (int r = 0; r < 3; r++) begin
      clear_sched();
      for (int i = 1; i < SLEN; i++) begin
        ev_sched[i] = ($urandom_range(0, 3) == 0);
        rst_sched[i] = (i > 5) && ($urandom_range(0, 99) == 0);
      end
      run_scen(SLEN);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
